// File: rtl/uart_mmio_ctrl.sv
// UART memory-mapped controller: a 16-byte register window that feeds a TX FIFO
// and a small start/wait FSM toward a UART TX core. It also buffers one RX byte
// from a UART RX core and raises a level interrupt.
module uart_mmio_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
   parameter int          TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic        irq
);

   localparam int            PW      = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam logic [PW:0]   DEPTH_C = TX_DEPTH[PW:0];

   typedef enum logic [1:0] {IDLE, START, WAIT} tx_state_e;

   tx_state_e       state_q;
   logic [7:0]      fifo_q [TX_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q, count_d;
   logic            tx_start_q;
   logic [7:0]      tx_data_q;
   logic [31:0]     rdata_q, rdata_d;
   logic            irq_q;
   logic [7:0]      rx_byte_q;
   logic            rx_valid_q, rx_ovr_q, tx_ovf_q;
   logic            rx_ie_q, tx_ie_q;

   logic            hit, wr_tx, rd_rx, rd_stat, wr_ctrl;
   logic            push, pop, tx_full, tx_busy;
   logic [1:0]      off;

   // Byte-lane bits and upper store bits are deliberately don't-care.
   logic unused_ok;
   assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:8]};

   assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign off     = mem_addr[3:2];
   assign wr_tx   = mem_we & hit & (off == 2'd0);
   assign rd_rx   = mem_re & hit & (off == 2'd1);
   assign rd_stat = mem_re & hit & (off == 2'd2);
   assign wr_ctrl = mem_we & hit & (off == 2'd3);

   // Full is judged on the pre-pop count, so a push when full is dropped even
   // if the FSM pops in the same cycle.
   assign tx_full = (count_q == DEPTH_C);
   assign tx_busy = (state_q != IDLE) | (count_q != '0);
   assign push    = wr_tx & ~tx_full;
   assign pop     = (state_q == IDLE) & (count_q != '0);

   // Occupancy next-state: simultaneous push and pop cancel.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Load mux; reflects state before any same-cycle store.
   always_comb begin
      rdata_d = 32'h0;
      if (hit) begin
         case (off)
            2'd1:    rdata_d = {24'h0, rx_byte_q};
            2'd2:    rdata_d = {27'h0, tx_ovf_q, rx_ovr_q, rx_valid_q, tx_full, tx_busy};
            2'd3:    rdata_d = {30'h0, tx_ie_q, rx_ie_q};
            default: rdata_d = 32'h0;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the entry is not counted.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
   end

   // FIFO pointers and count; power-of-two depth makes pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // TX FSM: pop the head into tx_data, pulse tx_start for one cycle, then wait for done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_start_q <= 1'b0;
               if (count_q != '0) begin
                  state_q    <= START;
                  tx_data_q  <= fifo_q[rd_ptr_q];
                  tx_start_q <= 1'b1;
               end
            end
            START: begin
               tx_start_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: begin
               tx_start_q <= 1'b0;
               if (tx_done) state_q <= IDLE;
            end
            default: begin
               tx_start_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   // RX holding register, sticky error flags and interrupt enables; a flag
   // being set wins over a STATUS read clearing it in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_byte_q  <= 8'h0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         tx_ovf_q   <= 1'b0;
         rx_ie_q    <= 1'b0;
         tx_ie_q    <= 1'b0;
      end else begin
         if (rd_stat) begin
            rx_ovr_q <= 1'b0;
            tx_ovf_q <= 1'b0;
         end
         if (wr_tx & tx_full) tx_ovf_q <= 1'b1;
         if (rx_done) begin
            rx_byte_q  <= rx_data;
            rx_valid_q <= 1'b1;
            if (rx_valid_q & ~rd_rx) rx_ovr_q <= 1'b1;
         end else if (rd_rx) begin
            rx_valid_q <= 1'b0;
         end
         if (wr_ctrl) begin
            rx_ie_q <= mem_wdata[0];
            tx_ie_q <= mem_wdata[1];
         end
      end
   end

   // Registered load data and interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0;
         irq_q   <= 1'b0;
      end else begin
         if (mem_re) rdata_q <= rdata_d;
         irq_q <= (rx_ie_q & rx_valid_q) | (tx_ie_q & ~tx_busy);
      end
   end

   assign mem_rdata = rdata_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign irq       = irq_q;

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0100, the word-aligned base of the 16-byte register window.
REQ-002 The block SHALL have parameter TX_DEPTH, default 4, the TX FIFO depth in entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port mem_addr, input, 32, the CPU load/store byte address.
REQ-006 The block SHALL have port mem_wdata, input, 32, the store data.
REQ-007 The block SHALL have port mem_we, input, 1, the store strobe (one cycle per access).
REQ-008 The block SHALL have port mem_re, input, 1, the load strobe (one cycle per access).
REQ-009 The block SHALL have port mem_rdata, output, 32, the registered load data.
REQ-010 The block SHALL have port tx_start, output, 1, a one-cycle start pulse to the UART TX core.
REQ-011 The block SHALL have port tx_data, output, 8, the byte being transmitted, held stable from tx_start until tx_done.
REQ-012 The block SHALL have port tx_done, input, 1, a pulse from the UART TX core marking frame complete.
REQ-013 The block SHALL have port rx_data, input, 8, the received byte, valid when rx_done=1.
REQ-014 The block SHALL have port rx_done, input, 1, a pulse from the UART RX core.
REQ-015 The block SHALL have port irq, output, 1, a level interrupt.

Function
REQ-016 An access SHALL hit when mem_addr[31:4]==BASE_ADDR[31:4]; offset = mem_addr[3:2]; mem_addr[1:0] SHALL be ignored.
REQ-017 Offset 0 (TXDATA): a write SHALL push mem_wdata[7:0] if the FIFO is not full; a write while full SHALL be dropped and SHALL set the sticky bit tx_ovf; a read SHALL return 0.
REQ-018 Offset 1 (RXDATA): a read SHALL return {24'b0, rx_byte} and SHALL clear rx_valid; a write SHALL be ignored.
REQ-019 Offset 2 (STATUS): a read SHALL return {27'b0, tx_ovf, rx_ovr, rx_valid, tx_full, tx_busy}; the read SHALL clear tx_ovf and rx_ovr; a write SHALL be ignored.
REQ-020 Offset 3 (CTRL): a read or write SHALL access bit0 rx_ie and bit1 tx_ie; all other bits SHALL read 0.
REQ-021 mem_rdata SHALL update on the clock edge where mem_re=1 and SHALL hold otherwise; a miss SHALL return 0 (latency 1 cycle).
REQ-022 mem_re and mem_we in the same cycle SHALL both be honoured; the read SHALL return pre-write state.
REQ-023 tx_busy SHALL equal (FSM!=IDLE) OR (FIFO count!=0); tx_full SHALL equal (count==TX_DEPTH).
REQ-024 The TX FSM SHALL have states IDLE, START and WAIT.
REQ-025 IDLE->START SHALL occur when count!=0; on this edge the FSM SHALL latch the head into tx_data and pop it.
REQ-026 In START, tx_start SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-027 WAIT->IDLE SHALL occur on tx_done=1.
REQ-028 tx_done outside WAIT SHALL be ignored.
REQ-029 Back-to-back bytes SHALL have tx_start pulses at least 3 cycles apart.
REQ-030 A push and a pop in the same cycle SHALL both occur and leave count unchanged; a push when full SHALL be dropped even if a pop happens that cycle.
REQ-031 On rx_done, rx_byte<=rx_data and rx_valid<=1; if rx_valid was already 1 and no RXDATA read occurs that cycle, rx_ovr SHALL be set and the new byte SHALL overwrite the old.
REQ-032 rx_done coincident with an RXDATA read SHALL return the old byte, store the new byte, leave rx_valid=1 and not set rx_ovr.
REQ-033 irq SHALL be registered and equal (rx_ie & rx_valid) | (tx_ie & ~tx_busy).
REQ-034 FIFO pointers SHALL wrap modulo TX_DEPTH.

Reset
REQ-035 While rst=1 at a clock edge the block SHALL set: FSM to IDLE, FIFO empty, all pointers 0, tx_start=0, tx_data=0, mem_rdata=0, irq=0, rx_byte=0, rx_valid=0, tx_ovf=0, rx_ovr=0, rx_ie=0 and tx_ie=0.
REQ-036 A reset mid-frame SHALL abandon the byte without a further tx_start; a tx_done arriving after reset SHALL be ignored.

Verification
REQ-037 Write 0x41 to BASE+0 -> tx_start pulses within 2 cycles with tx_data=0x41; STATUS reads 0x1 until tx_done, then 0x0.
REQ-038 Write 5 bytes 0x10..0x14 back-to-back with tx_done withheld -> the first is taken by the FSM, 4 are queued, and none is dropped; a 6th write sets tx_ovf; a STATUS read returns bit4=1, then a re-read returns bit4=0.
REQ-039 rx_done with 0x5A, then rx_done with 0xA5 and no read -> RXDATA reads 0xA5; STATUS before it reads rx_ovr=1 and rx_valid=1.
REQ-040 rx_done with 0x33 in the same cycle as an RXDATA read of 0x22 -> the read returns 0x22, the next read returns 0x33, and rx_ovr=0.
REQ-041 CTRL=0x3 with an idle TX -> irq=1; then write TXDATA -> irq=0 until tx_done and an empty FIFO.
REQ-042 Assert rst in WAIT with 2 bytes queued, release it, pulse tx_done -> no tx_start occurs and STATUS reads 0x0.
